// File: rtl/compound_rr_forwarder.sv
// Round-robin merge of N_CH compound-message producers into one FIFO-buffered sync/notify output.
// Optional delivered-message counter enabled by defining COMPOUND_FWD_CNT_EN.
module compound_rr_forwarder #(
  parameter int N_CH  = 4,
  parameter int X_W   = 32,
  parameter int DEPTH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_mode,
  input  logic [N_CH*X_W-1:0]   in_x,
  input  logic [N_CH-1:0]       in_y,
  input  logic [N_CH-1:0]       in_sync,
  output logic [N_CH-1:0]       in_notify,
  input  logic [N_CH-1:0]       ch_en,
  input  logic                  flush,
  output logic                  out_mode,
  output logic [X_W-1:0]        out_x,
  output logic                  out_y,
  output logic [CH_W-1:0]       out_ch,
  input  logic                  out_sync,
  output logic                  out_notify,
  output logic                  busy,
  output logic [15:0]           msg_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // Handshake: a transfer happens on a channel only in a cycle where both its
  // sync (producer/consumer side) and notify (block side) are high.
  typedef enum logic {SEC_RUN = 1'b0, SEC_FLUSH = 1'b1} section_t;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            mode;
    logic [X_W-1:0]  x;
    logic            y;
  } entry_t;

  section_t          section;
  entry_t            mem [DEPTH];
  entry_t            head;
  entry_t            head_next;
  entry_t            push_e;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   grant_id;
  logic [CH_W-1:0]   idx;
  logic [N_CH-1:0]   grant;
  logic              found;
  logic              push;
  logic              pop;

  // Rotating-priority search starting at rr_ptr; full FIFO blocks grants even if a pop is pending.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    if (!rst && section == SEC_RUN && count < FULL) begin
      for (int k = 0; k < N_CH; k++) begin
        idx = CH_W'((int'(rr_ptr) + k) % N_CH);
        if (!found && in_sync[idx] && ch_en[idx]) begin
          grant[idx] = 1'b1;
          grant_id   = idx;
          found      = 1'b1;
        end
      end
    end
  end

  assign in_notify = grant;
  assign push      = |(grant & in_sync);
  assign pop       = out_sync && out_notify;

  always_comb begin
    push_e.ch   = grant_id;
    push_e.mode = in_mode[grant_id];
    push_e.x    = in_x[int'(grant_id)*X_W +: X_W];
    push_e.y    = in_y[grant_id];
  end

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (!push && pop)
      count_next = count - CNT_W'(1);
    rd_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    // An entry written this cycle into an otherwise empty FIFO becomes the next head.
    head_next = (push && wr_ptr == rd_next) ? push_e : mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_e;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rr_ptr     <= '0;
      section    <= SEC_RUN;
      out_notify <= 1'b0;
      head       <= '0;
    end else begin
      count      <= count_next;
      rd_ptr     <= rd_next;
      out_notify <= (count_next != '0);
      if (count_next != '0)
        head <= head_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        rr_ptr <= (int'(grant_id) == N_CH - 1) ? '0 : grant_id + CH_W'(1);
      end
      case (section)
        SEC_RUN:   if (flush) section <= SEC_FLUSH;
        SEC_FLUSH: if (count == '0 && !out_notify) section <= SEC_RUN;
        default:   section <= SEC_RUN;
      endcase
    end
  end

  assign out_mode = head.mode;
  assign out_x    = head.x;
  assign out_y    = head.y;
  assign out_ch   = head.ch;
  assign busy     = !rst && (count != '0 || section == SEC_FLUSH);

`ifdef COMPOUND_FWD_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (pop)
      cnt_q <= cnt_q + 16'd1;
  end
  assign msg_cnt = cnt_q;
`else
  assign msg_cnt = '0;
`endif

endmodule

// File: doc/compound_rr_forwarder.md
Name: compound_rr_forwarder

Overview:
Parametrised successor to the single-channel compound-message output block. It merges N_CH producer channels of compound messages {mode, x, y} onto one blocking sync/notify output. Arbitration is round-robin. A DEPTH-entry FIFO decouples producers from the consumer, and a two-section FSM supports flushing.

Parameters:
N_CH, 4, number of input channels (>=2)
X_W, 32, width of the compound field x
DEPTH, 4, FIFO entries (power of 2, >=2)
CH_W, $clog2(N_CH), derived width of the channel id

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous and active-high
in_mode  in  N_CH  per-channel mode (0=read, 1=write)
in_x  in  N_CH*X_W  per-channel x; channel i occupies bits [i*X_W +: X_W]
in_y  in  N_CH  per-channel y flag
in_sync  in  N_CH  producer i has a valid message
in_notify  out  N_CH  one-hot grant; block reads channel i this cycle
ch_en  in  N_CH  channel enable mask, sampled every cycle
flush  in  1  single-cycle request to stop accepting and drain
out_mode  out  1  mode of the FIFO head
out_x  out  X_W  x of the FIFO head
out_y  out  1  y of the FIFO head
out_ch  out  CH_W  source channel of the FIFO head
out_sync  in  1  consumer ready
out_notify  out  1  head valid (registered)
busy  out  1  FIFO not empty or FSM in SEC_FLUSH
msg_cnt  out  16  delivered-message count (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge):
  - count, wr_ptr, rd_ptr, rr_ptr = 0; section = SEC_RUN.
  - out_notify = 0; out_mode/out_x/out_y/out_ch = 0; msg_cnt = 0.
  - While rst=1, in_notify = 0 and busy = 0.
  - Reset mid-operation discards all FIFO contents; no delivery follows.
- Transfers:
  - Input transfer on channel i: in_sync[i] && in_notify[i].
  - Output transfer: out_sync && out_notify.
- Grant (combinational):
  - Only in SEC_RUN with count < DEPTH.
  - Search channels starting at rr_ptr, wrapping modulo N_CH.
  - First i with in_sync[i] && ch_en[i] gets in_notify[i] = 1; all others 0.
  - On a grant to g: rr_ptr <= (g+1) mod N_CH. No grant leaves rr_ptr unchanged.
- Push: writes {ch=g, mode, x, y} at wr_ptr; wr_ptr wraps at DEPTH.
- Full:
  - count == DEPTH means no grant, even if a pop occurs in the same cycle.
  - Push and pop in the same non-full, non-empty cycle leave count unchanged.
- Empty:
  - A pushed message is visible at out_* with out_notify=1 on the next cycle (latency 1).
  - No same-cycle bypass.
- Output:
  - out_* is a registered copy of the FIFO head, held stable while out_notify=1 && out_sync=0.
  - After a pop, the next head (if any) appears on the following cycle; out_notify drops only when the FIFO becomes empty.
- FSM:
  - SEC_RUN --flush--> SEC_FLUSH. Grants are disabled; the FIFO drains normally.
  - SEC_FLUSH --count==0 && out_notify==0--> SEC_RUN.
  - flush asserted in SEC_FLUSH is ignored.
  - flush with an empty FIFO returns to SEC_RUN on the next cycle.
- Data: fields pass unmodified; x is never truncated or extended.

Optional Feature:
- Macro: COMPOUND_FWD_CNT_EN.
- Defined:
  - msg_cnt increments by 1 on every output transfer and wraps 0xFFFF -> 0x0000.
  - Saturates never; cleared only by rst.
- Undefined: msg_cnt is tied to 0 and no counter register is synthesised.

Test Plan:
(N_CH=4, X_W=8, DEPTH=4 throughout.)
- Round-robin:
  - Stimulus: in_sync=4'b1111, ch_en=4'b1111, out_sync=1; x per channel = 8'h10+i.
  - Required: grants 0,1,2,3,0 on consecutive cycles; out_x sequence 10,11,12,13, each one cycle after its grant; out_ch matches.
- Full backpressure:
  - Stimulus: out_sync=0, in_sync[2]=1 continuous.
  - Required: four grants, then in_notify=0; count=4.
  - Then set out_sync=1 for one cycle: one pop, and the next cycle grants channel 2 again.
- Mask:
  - Stimulus: ch_en=4'b0101, in_sync=4'b1111.
  - Required: only channels 0 and 2 are granted, alternating; channels 1 and 3 never see in_notify.
- Flush:
  - Stimulus: 3 entries queued, flush pulse, out_sync=1.
  - Required: no grants for 3 cycles while 3 entries pop; busy falls once the FIFO is empty; section returns to SEC_RUN and grants resume.
- Reset mid-stream:
  - Stimulus: assert rst with 2 entries queued and out_sync=0.
  - Required: next cycle out_notify=0, out_x=0, busy=0, msg_cnt=0; the first post-reset grant goes to channel 0.
- Counter wrap (COMPOUND_FWD_CNT_EN defined):
  - Stimulus: 65537 deliveries.
  - Required: msg_cnt=1. With the macro undefined, msg_cnt stays 0.
